tree_sum_accumulator: RTL

- Downstream consumer of the tree adder's 10-bit final sum (sum3).
- Accepts a stream of sums over a valid/ready handshake and accumulates N samples into a block total.
- Presents the total on an output handshake, then clears and starts the next block.
- Sits between the combinational tree adder and any result sink (register file, display, UART formatter).

---
 rtl/tree_acc_pkg.sv | 26 ++
 rtl/tree_sum_accumulator_if.sv | 26 ++
 rtl/tree_acc_counter.sv | 25 ++
 rtl/tree_sum_accumulator.sv | 102 ++++++++++
 4 files changed

// File: rtl/tree_acc_pkg.sv
// Shared definitions for the tree adder result accumulator.
// State encodings, default widths and a clog2 helper for sizing and parameter checks.
package tree_acc_pkg;

    localparam int unsigned TREE_SUM_W = 10;
    localparam int unsigned TREE_ACC_W = 12;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Returns the number of bits needed to hold values 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tree_sum_accumulator_if.sv
// Handshake bundle between the tree adder stream, the accumulator and its result sink.
// master = producer/sink side, slave = accumulator side.
interface tree_sum_accumulator_if #(
    parameter int unsigned IN_W  = tree_acc_pkg::TREE_SUM_W,
    parameter int unsigned ACC_W = tree_acc_pkg::TREE_ACC_W
);
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    modport master (
        output clr, in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  clr, in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/tree_acc_counter.sv
// Modulo-N sample counter with enable, synchronous clear and terminal-count flag.
module tree_acc_counter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);
    assign tc = (count == W'(N - 1));

    // Count accepted samples, wrapping to zero after the N-th.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/tree_sum_accumulator.sv
// Accumulates N tree-adder sums into a block total and presents it on an output handshake.
// Optional macro TREE_ACC_SAT_EN: saturate the accumulator on carry out instead of wrapping.
module tree_sum_accumulator
    import tree_acc_pkg::*;
#(
    parameter int unsigned IN_W  = TREE_SUM_W,
    parameter int unsigned N     = 4,
    parameter int unsigned ACC_W = TREE_ACC_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    tree_sum_accumulator_if.slave  io
);
    localparam int unsigned CNT_W = (clog2(N) < 1) ? 1 : clog2(N);

    acc_state_t         state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_next;
    logic               carry;
    logic               accept;
    logic [CNT_W-1:0]   count;
    logic               tc;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [ACC_W-1:0]   out_sum_r;
    logic               out_ovf_r;

    assign accept  = io.in_valid & in_ready_r;
    assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(io.in_sum);
    assign carry   = sum_ext[ACC_W];

`ifdef TREE_ACC_SAT_EN
    // Once saturated, every further add carries again, so acc stays pinned at all-ones.
    assign acc_next = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    tree_acc_counter #(
        .N (N),
        .W (CNT_W)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (io.clr),
        .en      (accept & ~io.clr),
        .count   (count),
        .tc      (tc)
    );

    assign io.in_ready  = in_ready_r;
    assign io.out_valid = out_valid_r;
    assign io.out_sum   = out_sum_r;
    assign io.out_ovf   = out_ovf_r;
    assign io.busy      = (count != '0) | out_valid_r;

    // Block FSM and accumulator datapath; clr overrides everything but reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ACCUM;
            acc         <= '0;
            out_sum_r   <= '0;
            out_valid_r <= 1'b0;
            out_ovf_r   <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (io.clr) begin
            state       <= ACCUM;
            acc         <= '0;
            out_valid_r <= 1'b0;
            out_ovf_r   <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc       <= acc_next;
                        out_ovf_r <= out_ovf_r | carry;
                        if (tc) begin
                            out_sum_r   <= acc_next;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (io.out_ready) begin
                        acc         <= '0;
                        out_ovf_r   <= 1'b0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end
endmodule
